// File: rtl/rollback_ctrl.sv
// rollback_ctrl: TMR fault rollback sequencer (flush, refill, retry limit, sticky fatal)
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   tmr_error          voter mismatch flag
//   PC_Top_rollback    rollback PC from the PC history buffer
//   pc_override(_val)  force the PC register to the captured rollback PC
//   flush, stall       pipeline flush pulse and fetch/commit freeze
//   rollback_active    high during FLUSH and REFILL
//   fatal_error        sticky unrecoverable-fault flag
//   retry_count        consecutive rollbacks since the last clear window
//   rollback_count     lifetime rollbacks, saturating
module rollback_ctrl #(
   parameter int MAX_RETRY     = 3,
   parameter int REFILL_CYCLES = 3,
   parameter int CLEAR_WINDOW  = 8,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tmr_error,
   input  logic [31:0]      PC_Top_rollback,
   output logic             pc_override,
   output logic [31:0]      pc_override_val,
   output logic             flush,
   output logic             stall,
   output logic             rollback_active,
   output logic             fatal_error,
   output logic [3:0]       retry_count,
   output logic [CNT_W-1:0] rollback_count
);
   localparam int RW = $clog2(REFILL_CYCLES + 1);
   localparam int WW = $clog2(CLEAR_WINDOW + 1);
   typedef enum logic [1:0] {IDLE, FLUSH, REFILL, FATAL} state_t;
   state_t state, state_n;
   logic [31:0] rb_pc, rb_pc_n;
   logic [3:0] retry_n;
   logic [CNT_W-1:0] rb_cnt_n;
   logic [RW-1:0] refill, refill_n;
   logic [WW-1:0] win, win_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state          <= IDLE;
         rb_pc          <= '0;
         retry_count    <= '0;
         rollback_count <= '0;
         refill         <= '0;
         win            <= '0;
      end else begin
         state          <= state_n;
         rb_pc          <= rb_pc_n;
         retry_count    <= retry_n;
         rollback_count <= rb_cnt_n;
         refill         <= refill_n;
         win            <= win_n;
      end
   always_comb begin
      state_n  = state;
      rb_pc_n  = rb_pc;
      retry_n  = retry_count;
      rb_cnt_n = rollback_count;
      refill_n = refill;
      win_n    = win;
      case (state)
         IDLE:
            if (tmr_error && retry_count == 4'(MAX_RETRY))
               state_n = FATAL;
            else if (tmr_error) begin
               // an error on the clearing edge wins, so retry_count is not cleared first
               state_n  = FLUSH;
               rb_pc_n  = PC_Top_rollback;
               retry_n  = retry_count + 4'd1;
               rb_cnt_n = &rollback_count ? rollback_count : rollback_count + CNT_W'(1);
               win_n    = '0;
            end else begin
               win_n   = win == WW'(CLEAR_WINDOW) ? win : win + WW'(1);
               retry_n = win == WW'(CLEAR_WINDOW - 1) ? 4'd0 : retry_count;
            end
         FLUSH: begin
            state_n  = REFILL;
            refill_n = RW'(REFILL_CYCLES - 1);
         end
         REFILL: begin
            // errors here come from flushed instructions and are ignored
            state_n  = refill == '0 ? IDLE : REFILL;
            refill_n = refill == '0 ? refill : refill - RW'(1);
            win_n    = '0;
         end
         default: ;
      endcase
   end
   assign pc_override     = state == FLUSH;
   assign pc_override_val = rb_pc;
   assign flush           = state == FLUSH;
   assign stall           = state == FLUSH || state == FATAL;
   assign rollback_active = state == FLUSH || state == REFILL;
   assign fatal_error     = state == FATAL;
endmodule

// File: tb/tb_rollback_ctrl.sv
// tb_rollback_ctrl: directed self-checking bench for rollback_ctrl
module tb_rollback_ctrl;
   logic clk = 0;
   logic rst = 1;
   logic tmr_error = 0;
   logic [31:0] PC_Top_rollback = '0;
   logic pc_override, flush, stall, rollback_active, fatal_error;
   logic [31:0] pc_override_val;
   logic [3:0] retry_count;
   logic [15:0] rollback_count;
   int checks = 0;
   int errors = 0;
   int nflush;
   rollback_ctrl dut (
      .clk(clk), .rst(rst), .tmr_error(tmr_error), .PC_Top_rollback(PC_Top_rollback),
      .pc_override(pc_override), .pc_override_val(pc_override_val), .flush(flush),
      .stall(stall), .rollback_active(rollback_active), .fatal_error(fatal_error),
      .retry_count(retry_count), .rollback_count(rollback_count)
   );
   always #5 clk = ~clk;
   wire [4:0] ctl = {fatal_error, rollback_active, stall, flush, pc_override};
   localparam logic [4:0] C_IDLE = 5'b00000, C_FLUSH = 5'b01111, C_REFILL = 5'b01000, C_FATAL = 5'b10100;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic regs(input string tag, input logic [4:0] c, input int rc, input int lc);
      check({tag, " ctl"}, 32'(ctl), 32'(c));
      check({tag, " retry"}, 32'(retry_count), rc);
      check({tag, " lifetime"}, 32'(rollback_count), lc);
   endtask
   initial begin
      tick(2);
      regs("in_reset", C_IDLE, 0, 0);
      rst = 0;
      tick(20);
      regs("idle20", C_IDLE, 0, 0);
      check("idle20 val", pc_override_val, 0);
      // single pulse rollback
      PC_Top_rollback = 32'h40;
      tmr_error = 1;
      tick();
      tmr_error = 0;
      regs("single flush", C_FLUSH, 1, 1);
      check("single val", pc_override_val, 32'h40);
      PC_Top_rollback = 32'h99;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("single refill ctl", 32'(ctl), 32'(C_REFILL));
      end
      check("rb_pc held", pc_override_val, 32'h40);
      tick();
      regs("single idle", C_IDLE, 1, 1);
      tick(7);
      check("window 7", 32'(retry_count), 1);
      tick();
      check("window 8", 32'(retry_count), 0);
      // errors during FLUSH/REFILL are ignored
      PC_Top_rollback = 32'h80;
      tmr_error = 1;
      nflush = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         nflush += int'(flush);
      end
      tmr_error = 0;
      check("ignore flushes", nflush, 1);
      regs("ignore end", C_IDLE, 1, 2);
      check("ignore val", pc_override_val, 32'h80);
      // second rollback, then error lands exactly on the 8th clean IDLE edge
      tmr_error = 1;
      tick();
      tmr_error = 0;
      regs("retry2 flush", C_FLUSH, 2, 3);
      tick(4);
      tick(7);
      check("pre-window retry", 32'(retry_count), 2);
      tmr_error = 1;
      tick();
      tmr_error = 0;
      regs("window race", C_FLUSH, 3, 4);
      tick(4);
      regs("retry3 idle", C_IDLE, 3, 4);
      // at the retry limit the next error escalates with no counter change
      tmr_error = 1;
      tick();
      tmr_error = 0;
      regs("limit fatal", C_FATAL, 3, 4);
      #2 rst = 1;
      #1;
      regs("async rst fatal", C_IDLE, 0, 0);
      check("async rst val", pc_override_val, 0);
      rst = 0;
      // persistent error: three rollbacks then FATAL
      tmr_error = 1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         regs("held flush", C_FLUSH, k, k);
         tick(3);
         check("held refill ctl", 32'(ctl), 32'(C_REFILL));
         tick();
         check("held idle ctl", 32'(ctl), 32'(C_IDLE));
      end
      tick();
      regs("held fatal", C_FATAL, 3, 3);
      PC_Top_rollback = 32'h1234;
      for (int i = 0; i < 6; i++) begin
         tmr_error = i[0];
         tick();
      end
      regs("fatal sticky", C_FATAL, 3, 3);
      tick(12);
      regs("fatal window", C_FATAL, 3, 3);
      // async reset mid-REFILL, then a clean rollback
      #2 rst = 1;
      #1 rst = 0;
      tmr_error = 1;
      tick();
      tmr_error = 0;
      tick(2);
      check("pre-rst refill", 32'(ctl), 32'(C_REFILL));
      #3 rst = 1;
      #1;
      regs("async rst refill", C_IDLE, 0, 0);
      rst = 0;
      PC_Top_rollback = 32'h123;
      tmr_error = 1;
      tick();
      tmr_error = 0;
      regs("post-rst flush", C_FLUSH, 1, 1);
      check("post-rst val", pc_override_val, 32'h123);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
